// File: rtl/bs_refill_ctrl_if.sv
// Bitstream memory read port between bs_refill_ctrl and the external bitstream memory.
//   bs_req  : read request, held until acknowledged (single outstanding)
//   bs_addr : word address, stable while bs_req=1
//   bs_ack  : read acknowledge; bs_data is valid in the same cycle
//   bs_data : read data word
// Modports: master = refill controller side, slave = memory side.
interface bs_refill_ctrl_if #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned WORD_W = 16
) ();
    logic              bs_req;
    logic [ADDR_W-1:0] bs_addr;
    logic              bs_ack;
    logic [WORD_W-1:0] bs_data;

    modport master (output bs_req, output bs_addr, input bs_ack, input bs_data);
    modport slave  (input bs_req, input bs_addr, output bs_ack, output bs_data);
endinterface

// File: rtl/bs_refill_ctrl.sv
// Refill controller for the 128-bit circular bitstream buffer indexed by the
// parser's 7-bit bit pointer. Fetches WORD_W-bit words one at a time from the
// bitstream memory, writes them into buffer slots in circular order, tracks the
// number of unconsumed valid bits and stalls the parser when it runs low.
//
// Ports:
//   clk_i, reset_i       clock, synchronous active-high reset
//   start_i              one-cycle pulse, accepted only when idle
//   start_addr_i         first word address
//   end_addr_i           last word address (inclusive)
//   consume_len_i        bits consumed by the parser this cycle (0..16)
//   bs                   memory read port (bs_refill_ctrl_if.master)
//   buf_wr_en_o          buffer slot write strobe
//   buf_wr_slot_o        slot written
//   buf_wr_data_o        data written
//   valid_bits_o         unconsumed valid bits, 0..128
//   parser_stall_o       valid_bits < STALL_TH while not at end of stream
//                        (high out of reset, since the buffer is empty)
//   eos_o                sticky, last word written
//   underflow_err_o      sticky, parser consumed more bits than were valid
//
// Optional build macro BS_REFILL_STATS_EN adds saturating 32-bit counters
// stat_words_o (words written) and stat_stall_cycles_o (stalled non-idle cycles).
module bs_refill_ctrl #(
    parameter int unsigned WORD_W   = 16,
    parameter int unsigned SLOTS    = 8,
    parameter int unsigned STALL_TH = 32,
    parameter int unsigned ADDR_W   = 17
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [ADDR_W-1:0] end_addr_i,
    input  logic [4:0]        consume_len_i,
    bs_refill_ctrl_if.master  bs,
    output logic              buf_wr_en_o,
    output logic [2:0]        buf_wr_slot_o,
    output logic [WORD_W-1:0] buf_wr_data_o,
    output logic [7:0]        valid_bits_o,
    output logic              parser_stall_o,
    output logic              eos_o,
    output logic              underflow_err_o
`ifdef BS_REFILL_STATS_EN
    ,
    output logic [31:0]       stat_words_o,
    output logic [31:0]       stat_stall_cycles_o
`endif
);

    localparam logic [8:0] WORD_ADD = 9'(WORD_W);
    localparam logic [8:0] ROOM_MAX = 9'(WORD_W * SLOTS - WORD_W);
    localparam logic [7:0] STALL_8  = 8'(STALL_TH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_REQ,
        S_WRITE,
        S_EOS
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        fill_q, fill_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [7:0]        valid_q, valid_d;
    logic              eos_q, eos_d;
    logic              uf_q, uf_d;

    logic [8:0]        avail;
    logic [8:0]        consume9;
    logic              under;
    logic [8:0]        occ_next;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            fill_q  <= '0;
            word_q  <= '0;
            valid_q <= '0;
            eos_q   <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            fill_q  <= fill_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            eos_q   <= eos_d;
            uf_q    <= uf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        fill_d  = fill_q;
        word_d  = word_q;
        valid_d = valid_q;
        eos_d   = eos_q;
        uf_d    = uf_q;

        // Write and consume in the same cycle are both applied; an over-consume
        // clamps occupancy to zero and latches the error.
        avail    = {1'b0, valid_q} + ((state_q == S_WRITE) ? WORD_ADD : 9'd0);
        consume9 = {4'b0, consume_len_i};
        under    = consume9 > avail;
        occ_next = under ? 9'd0 : avail - consume9;

        if (state_q != S_IDLE) begin
            valid_d = occ_next[7:0];
            if (under) begin
                uf_d = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    addr_d  = start_addr_i;
                    eos_d   = 1'b0;
                    uf_d    = 1'b0;
                    fill_d  = '0;
                    valid_d = '0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (addr_q > end_addr_i) begin
                    eos_d   = 1'b1;
                    state_d = S_EOS;
                end else if (occ_next <= ROOM_MAX) begin
                    // Room for a whole word: the target slot is already fully consumed.
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bs.bs_ack) begin
                    word_d  = bs.bs_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                fill_d  = fill_q + 3'(1);
                addr_d  = addr_q + ADDR_W'(1);
                state_d = S_CHECK;
            end
            S_EOS: begin
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bs.bs_req       = (state_q == S_REQ);
    assign bs.bs_addr      = addr_q;
    assign buf_wr_en_o     = (state_q == S_WRITE);
    assign buf_wr_slot_o   = fill_q;
    assign buf_wr_data_o   = word_q;
    assign valid_bits_o    = valid_q;
    assign parser_stall_o  = (valid_q < STALL_8) && !eos_q;
    assign eos_o           = eos_q;
    assign underflow_err_o = uf_q;

`ifdef BS_REFILL_STATS_EN
    logic [31:0] words_q, stall_q;

    always_ff @(posedge clk_i) begin
        if (reset_i || (state_q == S_IDLE && start_i)) begin
            words_q <= '0;
            stall_q <= '0;
        end else begin
            if (state_q == S_WRITE && words_q != '1) begin
                words_q <= words_q + 32'd1;
            end
            if (parser_stall_o && state_q != S_IDLE && stall_q != '1) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign stat_words_o        = words_q;
    assign stat_stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_bs_refill_ctrl.sv
// Directed bench for bs_refill_ctrl: a memory responder with programmable ack
// delay, a write monitor collecting buffer writes, and a linear sequence of
// steps with hand-computed expectations.
module tb_bs_refill_ctrl;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_i = 1'b0;
    logic [16:0] start_addr_i = '0;
    logic [16:0] end_addr_i = '0;
    logic [4:0]  consume_len_i = '0;
    logic        buf_wr_en_o;
    logic [2:0]  buf_wr_slot_o;
    logic [15:0] buf_wr_data_o;
    logic [7:0]  valid_bits_o;
    logic        parser_stall_o;
    logic        eos_o;
    logic        underflow_err_o;
`ifdef BS_REFILL_STATS_EN
    logic [31:0] stat_words_o;
    logic [31:0] stat_stall_cycles_o;
`endif

    bs_refill_ctrl_if #(.ADDR_W(17), .WORD_W(16)) bs ();

    bs_refill_ctrl #(.WORD_W(16), .SLOTS(8), .STALL_TH(32), .ADDR_W(17)) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .start_i         (start_i),
        .start_addr_i    (start_addr_i),
        .end_addr_i      (end_addr_i),
        .consume_len_i   (consume_len_i),
        .bs              (bs),
        .buf_wr_en_o     (buf_wr_en_o),
        .buf_wr_slot_o   (buf_wr_slot_o),
        .buf_wr_data_o   (buf_wr_data_o),
        .valid_bits_o    (valid_bits_o),
        .parser_stall_o  (parser_stall_o),
        .eos_o           (eos_o),
        .underflow_err_o (underflow_err_o)
`ifdef BS_REFILL_STATS_EN
        ,
        .stat_words_o        (stat_words_o),
        .stat_stall_cycles_o (stat_stall_cycles_o)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned ack_dly = 1;
    logic        force_ack = 1'b0;
    logic [18:0] wq[$];

    function automatic logic [15:0] word_of(input logic [16:0] a);
        return a[15:0] ^ 16'h5A3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Memory model: ack after ack_dly idle request cycles, data derived from address.
    initial begin
        int unsigned wait_cnt;
        wait_cnt = 0;
        bs.bs_ack = 1'b0;
        bs.bs_data = '0;
        forever begin
            @(negedge clk);
            if (force_ack) begin
                bs.bs_ack = 1'b1;
                bs.bs_data = 16'hDEAD;
            end else if (bs.bs_req) begin
                if (wait_cnt >= ack_dly) begin
                    bs.bs_ack = 1'b1;
                    bs.bs_data = word_of(bs.bs_addr);
                    wait_cnt = 0;
                end else begin
                    bs.bs_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                bs.bs_ack = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (buf_wr_en_o) wq.push_back({buf_wr_slot_o, buf_wr_data_o});
    end

    task automatic do_start(input logic [16:0] sa, input logic [16:0] ea);
        start_addr_i = sa;
        end_addr_i = ea;
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        tick(2);
        reset_i = 1'b0;
    endtask

    initial begin
        int unsigned cnt;
        logic        req_seen;
        logic [2:0]  es;
        logic [16:0] ea;

        // Reset state
        tick(3);
        reset_i = 1'b0;
        chk("rst_req", bs.bs_req, 0);
        chk("rst_addr", bs.bs_addr, 0);
        chk("rst_wr_en", buf_wr_en_o, 0);
        chk("rst_valid", valid_bits_o, 0);
        chk("rst_eos", eos_o, 0);
        chk("rst_uf", underflow_err_o, 0);
        chk("rst_stall_empty", parser_stall_o, 1);

        // Fill from 0x100, ack one cycle after request, no consumption
        ack_dly = 1;
        wq.delete();
        do_start(17'h100, 17'h1FF);
        cnt = 0;
        while (valid_bits_o != 8'd128 && cnt < 200) begin
            if (valid_bits_o == 8'd16) chk("stall_at_16", parser_stall_o, 1);
            if (valid_bits_o == 8'd32) chk("stall_at_32", parser_stall_o, 0);
            tick(1);
            cnt++;
        end
        chk("fill_timeout", cnt < 200, 1);
        req_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bs.bs_req) req_seen = 1'b1;
            tick(1);
        end
        chk("full_no_req", req_seen, 0);
        chk("full_valid", valid_bits_o, 128);
        chk("full_stall", parser_stall_o, 0);
        chk("full_next_addr", bs.bs_addr, 17'h108);
        chk("fill_writes", wq.size(), 8);
        for (int i = 0; i < 8 && i < wq.size(); i++) begin
            ea = 17'h100 + 17'(i);
            chk("fill_slot", wq[i][18:16], i);
            chk("fill_data", wq[i][15:0], word_of(ea));
        end

        // One symbol consumed from full: exactly one refill into slot 0
        wq.delete();
        consume_len_i = 5'd16;
        tick(1);
        consume_len_i = 5'd0;
        chk("cons16_valid", valid_bits_o, 112);
        chk("cons16_req", bs.bs_req, 1);
        chk("cons16_addr", bs.bs_addr, 17'h108);
        cnt = 0;
        while (valid_bits_o != 8'd128 && cnt < 50) begin
            tick(1);
            cnt++;
        end
        chk("refill_timeout", cnt < 50, 1);
        tick(5);
        chk("refill_writes", wq.size(), 1);
        if (wq.size() > 0) chk("refill_word", wq[0], {3'd0, word_of(17'h108)});

        // Steady consume 5/cycle for 32 cycles with 4-cycle ack delay: 160 bits = 10 words
        wq.delete();
        ack_dly = 4;
        consume_len_i = 5'd5;
        tick(32);
        consume_len_i = 5'd0;
        chk("steady_uf", underflow_err_o, 0);
        cnt = 0;
        while (!(valid_bits_o == 8'd128 && !bs.bs_req) && cnt < 300) begin
            tick(1);
            cnt++;
        end
        chk("steady_timeout", cnt < 300, 1);
        tick(10);
        chk("steady_writes", wq.size(), 10);
        for (int i = 0; i < 10 && i < wq.size(); i++) begin
            es = 3'(1 + i);
            ea = 17'h109 + 17'(i);
            chk("steady_slot", wq[i][18:16], es);
            chk("steady_data", wq[i][15:0], word_of(ea));
        end
        chk("steady_uf_end", underflow_err_o, 0);
        chk("steady_addr", bs.bs_addr, 17'h113);

        // Short stream of 3 words, then end of stream and drain
        do_reset();
        ack_dly = 0;
        wq.delete();
        do_start(17'h200, 17'h202);
        cnt = 0;
        while (!eos_o && cnt < 100) begin
            tick(1);
            cnt++;
        end
        chk("eos_timeout", cnt < 100, 1);
        tick(2);
        chk("eos_writes", wq.size(), 3);
        for (int i = 0; i < 3 && i < wq.size(); i++) begin
            ea = 17'h200 + 17'(i);
            chk("eos_word", wq[i], {3'(i), word_of(ea)});
        end
        chk("eos_valid", valid_bits_o, 48);
        consume_len_i = 5'd16;
        tick(3);
        consume_len_i = 5'd0;
        chk("drain_valid", valid_bits_o, 0);
        chk("drain_stall", parser_stall_o, 0);
        chk("drain_uf", underflow_err_o, 0);
        req_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bs.bs_req) req_seen = 1'b1;
            tick(1);
        end
        chk("eos_no_req", req_seen, 0);
        chk("eos_sticky", eos_o, 1);

        // Underflow: one-word stream, consume 8 then 16 with only 8 valid
        do_reset();
        do_start(17'h300, 17'h300);
        cnt = 0;
        while (!eos_o && cnt < 100) begin
            tick(1);
            cnt++;
        end
        chk("uf_eos_timeout", cnt < 100, 1);
        chk("uf_pre_valid", valid_bits_o, 16);
        consume_len_i = 5'd8;
        tick(1);
        chk("uf_valid8", valid_bits_o, 8);
        chk("uf_none_yet", underflow_err_o, 0);
        consume_len_i = 5'd16;
        tick(1);
        consume_len_i = 5'd0;
        chk("uf_valid0", valid_bits_o, 0);
        chk("uf_set", underflow_err_o, 1);
        tick(5);
        chk("uf_sticky", underflow_err_o, 1);
        chk("uf_stall_eos", parser_stall_o, 0);
        do_reset();
        chk("uf_cleared", underflow_err_o, 0);

        // Reset during an outstanding request, then a late ack
        ack_dly = 1000;
        do_start(17'h400, 17'h4FF);
        cnt = 0;
        while (!bs.bs_req && cnt < 20) begin
            tick(1);
            cnt++;
        end
        chk("hs_req_up", bs.bs_req, 1);
        chk("hs_addr", bs.bs_addr, 17'h400);
        wq.delete();
        reset_i = 1'b1;
        tick(1);
        chk("hs_req_dropped", bs.bs_req, 0);
        reset_i = 1'b0;
        force_ack = 1'b1;
        tick(3);
        force_ack = 1'b0;
        tick(3);
        chk("late_ack_no_write", wq.size(), 0);
        chk("late_ack_req", bs.bs_req, 0);
        chk("late_ack_addr", bs.bs_addr, 0);
        chk("late_ack_valid", valid_bits_o, 0);
        chk("late_ack_wr", {buf_wr_en_o, buf_wr_slot_o, buf_wr_data_o}, 0);
        chk("late_ack_flags", {eos_o, underflow_err_o}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
